// File: rtl/fpu_divider.sv
// rtl/fpu_divider.sv - restoring mantissa divider, one quotient bit per cycle; optional sticky via FPU_DIV_STICKY_EN
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

module fpu_divider #(
    parameter int  FRAC_WIDTH = `FP16_FRACW,
    localparam int W          = FRAC_WIDTH + 1,
    localparam int QW         = 2 * W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  divIn1,
    input  logic [W-1:0]  divIn2,
    input  logic          start,
    output logic [QW-1:0] divOut,
    output logic [W-1:0]  divRem,
    output logic          divByZero,
    output logic          divSticky,
    output logic          done
);

    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        DIV_WAIT,
        DIV_INIT,
        DIV_ITER,
        DIV_DONE
    } div_state_t;

    div_state_t    state;
    div_state_t    next_state;

    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    // Numerator (dividend << W) streamed out MSB first, one bit per iteration
    logic [QW-1:0] num_shift;
    // One spare bit so the shifted remainder never overflows before the compare
    logic [W:0]    rem;
    logic [QW-1:0] quo;
    logic [CW-1:0] count;
    logic          dbz;

    logic [W:0]    rem_shift;
    logic [W:0]    rem_sub;
    logic [W:0]    rem_next;
    logic          fits;

    // One restoring step: shift in the next numerator bit, subtract divisor if it fits
    always_comb begin
        rem_shift = (rem << 1) | {{W{1'b0}}, num_shift[QW-1]};
        rem_sub   = rem_shift - {1'b0, divisor};
        fits      = (rem_shift >= {1'b0, divisor});
        rem_next  = fits ? rem_sub : rem_shift;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DIV_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured when idle or holding a result
    always_comb begin
        next_state = state;
        case (state)
            DIV_WAIT: if (start) next_state = DIV_INIT;
            DIV_INIT: next_state = (divisor == '0) ? DIV_DONE : DIV_ITER;
            DIV_ITER: if (count == '0) next_state = DIV_DONE;
            DIV_DONE: if (start) next_state = DIV_INIT;
            default:  next_state = DIV_WAIT;
        endcase
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            dividend  <= '0;
            divisor   <= '0;
            num_shift <= '0;
            rem       <= '0;
            quo       <= '0;
            count     <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                DIV_WAIT, DIV_DONE: begin
                    if (start) begin
                        dividend <= divIn1;
                        divisor  <= divIn2;
                    end
                end
                DIV_INIT: begin
                    if (divisor == '0) begin
                        quo <= '1;
                        rem <= {1'b0, dividend};
                        dbz <= 1'b1;
                    end else begin
                        quo       <= '0;
                        rem       <= '0;
                        num_shift <= {dividend, {W{1'b0}}};
                        count     <= CW'(QW - 1);
                        dbz       <= 1'b0;
                    end
                end
                DIV_ITER: begin
                    rem       <= rem_next;
                    quo       <= {quo[QW-2:0], fits};
                    num_shift <= num_shift << 1;
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_DIV_STICKY_EN
    logic sticky;

    // Sticky is registered alongside the final remainder so it is stable with done
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (state == DIV_INIT) begin
            sticky <= (divisor == '0) && (dividend != '0);
        end else if (state == DIV_ITER && count == '0) begin
            sticky <= (rem_next != '0);
        end
    end

    assign divSticky = sticky;
`else
    assign divSticky = 1'b0;
`endif

    assign divOut    = quo;
    assign divRem    = rem[W-1:0];
    assign divByZero = dbz;
    assign done      = (state == DIV_DONE);

endmodule

// File: tb/tb_fpu_divider.sv
// tb/tb_fpu_divider.sv - self-checking bench for fpu_divider with arithmetic reference model
module tb_fpu_divider;

    localparam int W       = 11;
    localparam int QW      = 22;
    localparam int LAT_DIV = QW + 2;
    localparam int LAT_DBZ = 2;

`ifdef FPU_DIV_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  divIn1 = '0;
    logic [W-1:0]  divIn2 = '0;
    logic [QW-1:0] divOut;
    logic [W-1:0]  divRem;
    logic          divByZero;
    logic          divSticky;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_divider dut (
        .clock     (clock),
        .reset     (reset),
        .divIn1    (divIn1),
        .divIn2    (divIn2),
        .start     (start),
        .divOut    (divOut),
        .divRem    (divRem),
        .divByZero (divByZero),
        .divSticky (divSticky),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: quotient/remainder by plain integer arithmetic, done by cycle count
    int            m_cnt   = 0;
    bit            m_done  = 1'b0;
    bit            m_clear = 1'b0;
    logic [QW-1:0] m_q     = '0;
    logic [W-1:0]  m_r     = '0;
    bit            m_dbz   = 1'b0;
    bit            m_st    = 1'b0;

    always @(posedge clock) begin : model
        longint unsigned num;
        if (reset) begin
            m_cnt   = 0;
            m_done  = 1'b0;
            m_clear = 1'b1;
        end else if (start && m_cnt == 0) begin
            num = 64'(divIn1) << W;
            if (divIn2 == '0) begin
                m_q   = '1;
                m_r   = divIn1;
                m_dbz = 1'b1;
                m_st  = STICKY_ON && (divIn1 != '0);
                m_cnt = LAT_DBZ - 1;
            end else begin
                m_q   = QW'(num / 64'(divIn2));
                m_r   = W'(num % 64'(divIn2));
                m_dbz = 1'b0;
                m_st  = STICKY_ON && (m_r != '0);
                m_cnt = LAT_DIV - 1;
            end
            m_done  = 1'b0;
            m_clear = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clock) begin
        check("cyc_done", 64'(done), 64'(m_done));
        if (m_done) begin
            check("cyc_divOut", 64'(divOut), 64'(m_q));
            check("cyc_divRem", 64'(divRem), 64'(m_r));
            check("cyc_divByZero", 64'(divByZero), 64'(m_dbz));
            check("cyc_divSticky", 64'(divSticky), 64'(m_st));
        end else if (m_clear) begin
            check("cyc_clr_divOut", 64'(divOut), 64'(0));
            check("cyc_clr_divRem", 64'(divRem), 64'(0));
            check("cyc_clr_divByZero", 64'(divByZero), 64'(0));
            check("cyc_clr_divSticky", 64'(divSticky), 64'(0));
        end
    end

    task automatic wait_done(input string tag, inout int cyc);
        while (!done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", tag, cyc);
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [QW-1:0] eq, input logic [W-1:0] er,
                           input bit edbz, input bit est, input int elat);
        int cyc;
        @(posedge clock); #1;
        divIn1 = a;
        divIn2 = b;
        start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        divIn1 = W'($urandom);
        divIn2 = W'($urandom);
        cyc    = 1;
        check({tag, "_done_low"}, 64'(done), 64'(0));
        wait_done(tag, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(elat));
        check({tag, "_divOut"}, 64'(divOut), 64'(eq));
        check({tag, "_divRem"}, 64'(divRem), 64'(er));
        check({tag, "_divByZero"}, 64'(divByZero), 64'(edbz));
        check({tag, "_divSticky"}, 64'(divSticky), 64'(est));
    endtask

    initial begin : stim
        int cyc;

        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 64'(done), 64'(0));
        check("rst_divOut", 64'(divOut), 64'(0));
        check("rst_divRem", 64'(divRem), 64'(0));
        check("rst_divSticky", 64'(divSticky), 64'(0));
        reset = 1'b0;

        run_div("one",      11'h400, 11'h400, 22'h000800, 11'h000, 1'b0, 1'b0,      24);
        run_div("two3rds",  11'h400, 11'h600, 22'h000555, 11'h200, 1'b0, STICKY_ON, 24);
        run_div("maxmant",  11'h7FF, 11'h400, 22'h000FFE, 11'h000, 1'b0, 1'b0,      24);
        run_div("dbz",      11'h5A5, 11'h000, 22'h3FFFFF, 11'h5A5, 1'b1, STICKY_ON, 2);
        run_div("dbz_zero", 11'h000, 11'h000, 22'h3FFFFF, 11'h000, 1'b1, 1'b0,      2);
        run_div("maxmax",   11'h7FF, 11'h7FF, 22'h000800, 11'h000, 1'b0, 1'b0,      24);
        run_div("half",     11'h400, 11'h7FF, 22'h000400, 11'h400, 1'b0, STICKY_ON, 24);
        run_div("zero_num", 11'h000, 11'h005, 22'h000000, 11'h000, 1'b0, 1'b0,      24);
        run_div("ones",     11'h001, 11'h001, 22'h000800, 11'h000, 1'b0, 1'b0,      24);

        // Reset ten cycles into a division
        @(posedge clock); #1;
        divIn1 = 11'h7FF;
        divIn2 = 11'h003;
        start  = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_divOut", 64'(divOut), 64'(0));
        check("midrst_divRem", 64'(divRem), 64'(0));
        repeat (30) @(posedge clock);
        #1;
        check("midrst_idle", 64'(done), 64'(0));
        run_div("after_rst", 11'h400, 11'h400, 22'h000800, 11'h000, 1'b0, 1'b0, 24);

        // Reset wins over start on the same edge (a divide-by-zero would finish in 2)
        @(posedge clock); #1;
        reset  = 1'b1;
        start  = 1'b1;
        divIn1 = 11'h123;
        divIn2 = 11'h000;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("rst_prio_done", 64'(done), 64'(0));
        check("rst_prio_divOut", 64'(divOut), 64'(0));

        // start during iteration is ignored
        @(posedge clock); #1;
        divIn1 = 11'h400;
        divIn2 = 11'h600;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        divIn1 = 11'h7FF;
        divIn2 = 11'h400;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc   = 7;
        wait_done("repulse", cyc);
        check("repulse_latency", 64'(cyc), 64'(24));
        check("repulse_divOut", 64'(divOut), 64'(22'h000555));
        check("repulse_divRem", 64'(divRem), 64'(11'h200));

        // start while holding a result launches a new division
        run_div("from_done", 11'h7FF, 11'h400, 22'h000FFE, 11'h000, 1'b0, 1'b0, 24);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
